// File: rtl/branch_resolve.sv
// Branch resolution unit: evaluates branch conditions against the flag register, issues a fetch redirect, then flushes.
// Optional FLAG_FORWARD_EN: a same-cycle flag write is bypassed into the condition evaluation.

package branch_resolve_pkg;
    localparam int unsigned WORD_W  = 16;
    localparam int unsigned TAKEN_W = 16;

    typedef logic [WORD_W-1:0] word_16;

    typedef struct packed {
        logic zero;
        logic sign;
        logic overflow;
    } status_t;
endpackage

module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int unsigned FLUSH_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  status_t            stat_in,
    input  logic               flag_we,
    input  logic               br_valid,
    input  logic [1:0]         br_cond,
    input  word_16             br_target,
    output logic               br_ready,
    output logic               redirect_valid,
    output word_16             redirect_pc,
    input  logic               redirect_ack,
    output logic               flush,
    output status_t            flags_q,
    output logic [TAKEN_W-1:0] taken_cnt
);

    localparam int unsigned FCNT_W = 4;

    localparam logic [1:0] COND_EQ = 2'b00;
    localparam logic [1:0] COND_LT = 2'b01;
    localparam logic [1:0] COND_GT = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        REDIRECT,
        FLUSH
    } state_t;

    state_t              state;
    logic [FCNT_W-1:0]   flush_cnt;

    status_t             cond_src_c;
    logic                accept_c;
    logic                lt_c;
    logic                taken_c;
    logic [TAKEN_W-1:0]  cnt_nxt_c;

    // Condition evaluation and saturating taken-count update
    always_comb begin
        accept_c   = br_valid && br_ready;
`ifdef FLAG_FORWARD_EN
        cond_src_c = (flag_we && accept_c) ? stat_in : flags_q;
`else
        cond_src_c = flags_q;
`endif
        lt_c    = cond_src_c.sign ^ cond_src_c.overflow;
        taken_c = 1'b1;
        case (br_cond)
            COND_EQ: taken_c = cond_src_c.zero;
            COND_LT: taken_c = lt_c;
            COND_GT: taken_c = !cond_src_c.zero && !lt_c;
            default: taken_c = 1'b1;
        endcase

        cnt_nxt_c = taken_cnt;
        if (accept_c && taken_c && (taken_cnt != {TAKEN_W{1'b1}})) begin
            cnt_nxt_c = taken_cnt + TAKEN_W'(1);
        end
    end

    // Control FSM; status outputs are registered alongside the state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            flags_q        <= '0;
            redirect_pc    <= '0;
            flush_cnt      <= '0;
            taken_cnt      <= '0;
            br_ready       <= 1'b1;
            redirect_valid <= 1'b0;
            flush          <= 1'b0;
        end else begin
            if (flag_we) begin
                flags_q <= stat_in;
            end
            taken_cnt <= cnt_nxt_c;

            case (state)
                IDLE: begin
                    if (accept_c && taken_c) begin
                        state          <= REDIRECT;
                        redirect_pc    <= br_target;
                        br_ready       <= 1'b0;
                        redirect_valid <= 1'b1;
                    end
                end
                REDIRECT: begin
                    if (redirect_ack) begin
                        state          <= FLUSH;
                        flush_cnt      <= FCNT_W'(FLUSH_DEPTH - 1);
                        redirect_valid <= 1'b0;
                        flush          <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == '0) begin
                        state    <= IDLE;
                        flush    <= 1'b0;
                        br_ready <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt - FCNT_W'(1);
                    end
                end
                default: begin
                    state          <= IDLE;
                    br_ready       <= 1'b1;
                    redirect_valid <= 1'b0;
                    flush          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: expected redirect PCs are queued on accepted branches and popped on redirect.

module tb_branch_resolve;
    import branch_resolve_pkg::*;

    localparam int unsigned FD = 2;

    logic        clk;
    logic        rst_n;
    status_t     stat_in;
    logic        flag_we;
    logic        br_valid;
    logic [1:0]  br_cond;
    word_16      br_target;
    logic        br_ready;
    logic        redirect_valid;
    word_16      redirect_pc;
    logic        redirect_ack;
    logic        flush;
    status_t     flags_q;
    logic [15:0] taken_cnt;

    branch_resolve #(.FLUSH_DEPTH(FD)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stat_in        (stat_in),
        .flag_we        (flag_we),
        .br_valid       (br_valid),
        .br_cond        (br_cond),
        .br_target      (br_target),
        .br_ready       (br_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ack   (redirect_ack),
        .flush          (flush),
        .flags_q        (flags_q),
        .taken_cnt      (taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    word_16      exp_pc_q[$];
    logic [15:0] exp_cnt  = '0;
    status_t     exp_flags = '0;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        stat_in      = '0;
        flag_we      = 1'b0;
        br_valid     = 1'b0;
        br_cond      = 2'b00;
        br_target    = '0;
        redirect_ack = 1'b0;
    endtask

    task automatic load_flags(input status_t s);
        stat_in = s;
        flag_we = 1'b1;
        tick();
        flag_we   = 1'b0;
        exp_flags = s;
    endtask

    function automatic logic cond_model(input status_t f, input logic [1:0] c);
        logic lt;
        lt = f.sign ^ f.overflow;
        case (c)
            2'b00:   return f.zero;
            2'b01:   return lt;
            2'b10:   return !f.zero && !lt;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Acknowledge the pending redirect and count flush cycles until ready returns
    task automatic complete_redirect(output int n_flush, output bit ok);
        redirect_ack = 1'b1;
        tick();
        redirect_ack = 1'b0;
        n_flush = 0;
        ok      = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (flush) n_flush++;
            else if (br_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (br_ready !== 1'b1) begin failures++; $display("FAIL reset_br_ready: got %b want 1", br_ready); end
        checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL reset_redirect_valid: got %b want 0", redirect_valid); end
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL reset_flush: got %b want 0", flush); end
        checks++; if (flags_q !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b want 000", flags_q); end
        checks++; if (taken_cnt !== 16'h0000) begin failures++; $display("FAIL reset_taken_cnt: got %h want 0000", taken_cnt); end
        checks++; if (redirect_pc !== 16'h0000) begin failures++; $display("FAIL reset_redirect_pc: got %h want 0000", redirect_pc); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_taken_eq();
        int     nf;
        bit     ok;
        word_16 e;
        load_flags(3'b100);
        checks++; if (flags_q !== exp_flags) begin failures++; $display("FAIL eq_flags_load: got %b want %b", flags_q, exp_flags); end
        br_valid  = 1'b1;
        br_cond   = 2'b00;
        br_target = 16'h0040;
        exp_pc_q.push_back(16'h0040);
        exp_cnt = sat_inc(exp_cnt);
        tick();
        br_valid = 1'b0;
        checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL eq_redirect_valid: got %b want 1", redirect_valid); end
        checks++; if (br_ready !== 1'b0) begin failures++; $display("FAIL eq_br_ready: got %b want 0", br_ready); end
        e = exp_pc_q.pop_front();
        checks++; if (redirect_pc !== e) begin failures++; $display("FAIL eq_redirect_pc: got %h want %h", redirect_pc, e); end
        checks++; if (taken_cnt !== exp_cnt) begin failures++; $display("FAIL eq_taken_cnt: got %0d want %0d", taken_cnt, exp_cnt); end
        complete_redirect(nf, ok);
        checks++; if (!ok || nf != FD) begin failures++; $display("FAIL eq_flush_len: got %0d cycles (ready=%0b) want %0d", nf, ok, FD); end
    endtask

    task automatic test_not_taken_lt();
        int rv_seen = 0;
        load_flags(3'b011);
        br_valid  = 1'b1;
        br_cond   = 2'b01;
        br_target = 16'h0badd;
        tick();
        br_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (redirect_valid !== 1'b0 || br_ready !== 1'b1) rv_seen++;
            tick();
        end
        checks++; if (rv_seen != 0) begin failures++; $display("FAIL lt_not_taken: got %0d redirect/busy cycles want 0", rv_seen); end
        checks++; if (taken_cnt !== exp_cnt) begin failures++; $display("FAIL lt_taken_cnt: got %0d want %0d", taken_cnt, exp_cnt); end
    endtask

    task automatic test_conditions();
        status_t     fl [6] = '{3'b010, 3'b000, 3'b100, 3'b011, 3'b000, 3'b001};
        logic [1:0]  cd [6] = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b00, 2'b11};
        logic        exp;
        int          nf;
        bit          ok;
        word_16      e;
        for (int i = 0; i < 6; i++) begin
            load_flags(fl[i]);
            br_valid  = 1'b1;
            br_cond   = cd[i];
            br_target = 16'h0100 + 16'(i);
            exp = cond_model(exp_flags, cd[i]);
            if (exp) begin
                exp_pc_q.push_back(16'h0100 + 16'(i));
                exp_cnt = sat_inc(exp_cnt);
            end
            tick();
            br_valid = 1'b0;
            checks++; if (redirect_valid !== exp) begin failures++; $display("FAIL cond_%0d_redirect: got %b want %b", i, redirect_valid, exp); end
            if (exp) begin
                e = exp_pc_q.pop_front();
                checks++; if (redirect_pc !== e) begin failures++; $display("FAIL cond_%0d_pc: got %h want %h", i, redirect_pc, e); end
                complete_redirect(nf, ok);
                checks++; if (!ok || nf != FD) begin failures++; $display("FAIL cond_%0d_flush: got %0d want %0d", i, nf, FD); end
            end
            checks++; if (taken_cnt !== exp_cnt) begin failures++; $display("FAIL cond_%0d_cnt: got %0d want %0d", i, taken_cnt, exp_cnt); end
        end
    endtask

    task automatic test_delayed_ack();
        int     nf;
        bit     ok;
        word_16 e;
        int     bad = 0;
        br_valid  = 1'b1;
        br_cond   = 2'b11;
        br_target = 16'h1234;
        exp_pc_q.push_back(16'h1234);
        exp_cnt = sat_inc(exp_cnt);
        tick();
        e = exp_pc_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            br_valid  = (i % 2 == 0);
            br_target = 16'hBEEF;
            tick();
            if (redirect_valid !== 1'b1 || redirect_pc !== e || taken_cnt !== exp_cnt) begin
                bad++;
                $display("FAIL delay_hold_%0d: got rv=%b pc=%h cnt=%0d want rv=1 pc=%h cnt=%0d",
                         i, redirect_valid, redirect_pc, taken_cnt, e, exp_cnt);
            end
        end
        checks++; if (bad != 0) failures++;
        br_valid = 1'b0;
        complete_redirect(nf, ok);
        checks++; if (!ok || nf != FD) begin failures++; $display("FAIL delay_flush: got %0d want %0d", nf, FD); end
        checks++; if (taken_cnt !== exp_cnt) begin failures++; $display("FAIL delay_cnt: got %0d want %0d", taken_cnt, exp_cnt); end
    endtask

    task automatic test_ack_outside();
        redirect_ack = 1'b1;
        tick();
        tick();
        redirect_ack = 1'b0;
        checks++; if (br_ready !== 1'b1 || flush !== 1'b0 || redirect_valid !== 1'b0) begin
            failures++; $display("FAIL stray_ack: got ready=%b flush=%b rv=%b want 1 0 0", br_ready, flush, redirect_valid);
        end
    endtask

    task automatic test_same_cycle_flag();
        logic   exp;
        int     nf;
        bit     ok;
        word_16 e;
        load_flags(3'b000);
        stat_in   = 3'b100;
        flag_we   = 1'b1;
        br_valid  = 1'b1;
        br_cond   = 2'b00;
        br_target = 16'h0080;
`ifdef FLAG_FORWARD_EN
        exp = cond_model(stat_in, 2'b00);
`else
        exp = cond_model(exp_flags, 2'b00);
`endif
        if (exp) begin
            exp_pc_q.push_back(16'h0080);
            exp_cnt = sat_inc(exp_cnt);
        end
        exp_flags = 3'b100;
        tick();
        flag_we  = 1'b0;
        br_valid = 1'b0;
        checks++; if (flags_q !== exp_flags) begin failures++; $display("FAIL fwd_flags: got %b want %b", flags_q, exp_flags); end
        checks++; if (redirect_valid !== exp) begin failures++; $display("FAIL fwd_taken: got %b want %b", redirect_valid, exp); end
        if (exp) begin
            e = exp_pc_q.pop_front();
            checks++; if (redirect_pc !== e) begin failures++; $display("FAIL fwd_pc: got %h want %h", redirect_pc, e); end
            complete_redirect(nf, ok);
        end
        checks++; if (taken_cnt !== exp_cnt) begin failures++; $display("FAIL fwd_cnt: got %0d want %0d", taken_cnt, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        localparam int P = FD + 2;
        word_16 e;
        int     ph;
        br_valid     = 1'b1;
        br_cond      = 2'b11;
        br_target    = 16'h0300;
        redirect_ack = 1'b1;
        exp_pc_q.push_back(16'h0300);
        exp_cnt = sat_inc(exp_cnt);
        tick();
        for (int k = 0; k < 2 * P; k++) begin
            ph = k % P;
            checks++;
            if (redirect_valid !== (ph == 0) || flush !== (ph >= 1 && ph <= FD) ||
                br_ready !== (ph == FD + 1) || taken_cnt !== exp_cnt) begin
                failures++;
                $display("FAIL b2b_cycle_%0d: got rv=%b fl=%b rdy=%b cnt=%0d want phase %0d cnt=%0d",
                         k, redirect_valid, flush, br_ready, taken_cnt, ph, exp_cnt);
            end
            if (ph == 0 && exp_pc_q.size() > 0) begin
                e = exp_pc_q.pop_front();
                checks++; if (redirect_pc !== e) begin failures++; $display("FAIL b2b_pc_%0d: got %h want %h", k, redirect_pc, e); end
            end
            if (ph == FD + 1) begin
                if (k == 2 * P - 1) begin
                    br_valid     = 1'b0;
                    redirect_ack = 1'b0;
                end else begin
                    br_target = 16'h0300 + 16'(k);
                    exp_pc_q.push_back(16'h0300 + 16'(k));
                    exp_cnt = sat_inc(exp_cnt);
                end
            end
            tick();
        end
        checks++; if (br_ready !== 1'b1 || redirect_valid !== 1'b0) begin failures++; $display("FAIL b2b_end: got rdy=%b rv=%b want 1 0", br_ready, redirect_valid); end
    endtask

    task automatic test_reset_mid_flow();
        int bad = 0;
        load_flags(3'b101);
        br_valid  = 1'b1;
        br_cond   = 2'b11;
        br_target = 16'h0200;
        tick();
        br_valid     = 1'b0;
        redirect_ack = 1'b1;
        tick();
        redirect_ack = 1'b0;
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL rst_pre_flush: got %b want 1", flush); end
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        exp_cnt   = '0;
        exp_flags = '0;
        exp_pc_q.delete();
        checks++; if (flush !== 1'b0 || br_ready !== 1'b1 || redirect_valid !== 1'b0) begin
            failures++; $display("FAIL rst_flush_ctl: got fl=%b rdy=%b rv=%b want 0 1 0", flush, br_ready, redirect_valid);
        end
        checks++; if (taken_cnt !== 16'h0000) begin failures++; $display("FAIL rst_flush_cnt: got %0d want 0", taken_cnt); end
        checks++; if (flags_q !== 3'b000) begin failures++; $display("FAIL rst_flush_flags: got %b want 000", flags_q); end
        // Reset while a redirect is still waiting for its ack
        br_valid = 1'b1;
        tick();
        br_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (redirect_valid !== 1'b0 || flush !== 1'b0) bad++;
            tick();
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL rst_redirect_abandon: got %0d active cycles want 0", bad); end
        checks++; if (taken_cnt !== exp_cnt) begin failures++; $display("FAIL rst_redirect_cnt: got %0d want %0d", taken_cnt, exp_cnt); end
    endtask

    task automatic test_saturation();
        int     nf;
        bit     ok;
        word_16 e;
        force dut.taken_cnt = 16'hFFFD;
        tick();
        release dut.taken_cnt;
        exp_cnt = 16'hFFFD;
        tick();
        checks++; if (taken_cnt !== exp_cnt) begin failures++; $display("FAIL sat_preload: got %h want %h", taken_cnt, exp_cnt); end
        for (int i = 0; i < 3; i++) begin
            br_valid  = 1'b1;
            br_cond   = 2'b11;
            br_target = 16'h0500 + 16'(i);
            exp_pc_q.push_back(16'h0500 + 16'(i));
            exp_cnt = sat_inc(exp_cnt);
            tick();
            br_valid = 1'b0;
            e = exp_pc_q.pop_front();
            checks++; if (redirect_valid !== 1'b1 || redirect_pc !== e) begin failures++; $display("FAIL sat_%0d_redirect: got rv=%b pc=%h want 1 %h", i, redirect_valid, redirect_pc, e); end
            checks++; if (taken_cnt !== exp_cnt) begin failures++; $display("FAIL sat_%0d_cnt: got %h want %h", i, taken_cnt, exp_cnt); end
            complete_redirect(nf, ok);
            checks++; if (!ok) begin failures++; $display("FAIL sat_%0d_timeout: got no ready want ready", i); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_taken_eq();
        test_not_taken_lt();
        test_conditions();
        test_delayed_ack();
        test_ack_outside();
        test_same_cycle_flag();
        test_back_to_back();
        test_reset_mid_flow();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want completion");
        $fatal(1, "timeout");
    end

endmodule
